// File: rtl/pipo_load_arbiter_pkg.sv
// rtl/pipo_load_arbiter_pkg.sv - shared state enum and hold counter width for the PIPO load arbiter
package pipo_ctrl_pkg;

  // IDLE accepts a request, LOAD strobes the PIPO register, HOLD enforces the lockout
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Wide enough for the largest lockout of 15 cycles
  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// rtl/pipo_load_arbiter_if.sv - requester/load bus between requesters and the PIPO load arbiter
interface pipo_load_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        Req_Valid_In;
  logic [N_REQ*DATA_W-1:0] Req_Data_In;
  logic [N_REQ-1:0]        Req_Ready_Out;
  logic                    Load_Data_Signal_Out;
  logic [DATA_W-1:0]       Parallel_Data_Out;
  logic [IDX_W-1:0]        Grant_Id_Out;
  logic                    Busy_Out;

  // Requester side: drives requests, observes accepts and the load bus
  modport master (
    output Req_Valid_In,
    output Req_Data_In,
    input  Req_Ready_Out,
    input  Load_Data_Signal_Out,
    input  Parallel_Data_Out,
    input  Grant_Id_Out,
    input  Busy_Out
  );

  // Arbiter side
  modport slave (
    input  Req_Valid_In,
    input  Req_Data_In,
    output Req_Ready_Out,
    output Load_Data_Signal_Out,
    output Parallel_Data_Out,
    output Grant_Id_Out,
    output Busy_Out
  );

endinterface

// File: rtl/pipo_load_arbiter_rr_arbiter.sv
// rtl/pipo_load_arbiter_rr_arbiter.sv - request arbiter, round-robin or fixed priority (PIPO_ARB_FIXED_PRIO_EN)
module pipo_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant,
  output logic [IDX_W-1:0] next_ptr
);

  logic [IDX_W-1:0] start;

`ifdef PIPO_ARB_FIXED_PRIO_EN
  // Lowest index always wins; the rotating pointer plays no part
  assign start = '0;
`else
  // Search begins one past the last granted requester
  assign start = ptr;
`endif

  // First requesting index found when walking upward from start with wrap-around
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_grant && req[IDX_W'(idx)]) begin
        any_grant             = 1'b1;
        grant[IDX_W'(idx)]    = 1'b1;
        grant_idx             = IDX_W'(idx);
      end
    end
  end

  // Pointer to use after this grant is taken: the next index, wrapping at N_REQ
  always_comb begin
    next_ptr = '0;
    if (int'(grant_idx) != N_REQ - 1) next_ptr = grant_idx + 1'b1;
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// rtl/pipo_load_arbiter.sv - arbitrates N requesters onto one PIPO register load; PIPO_ARB_FIXED_PRIO_EN selects fixed priority
module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic Enable_In,
  pipo_load_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t                 state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [DATA_W-1:0]      data_q;
  logic [IDX_W-1:0]       gid_q;

  logic [N_REQ-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   any_grant;
  logic                   accept_en;
  logic                   xfer;
  logic [DATA_W-1:0]      sel_data;

  pipo_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.Req_Valid_In),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant),
    .next_ptr  (next_ptr)
  );

  // Accepts are offered only while idle and enabled; grant is already qualified by valid
  assign accept_en         = (state == ST_IDLE) && Enable_In;
  assign xfer              = accept_en && any_grant;
  assign bus.Req_Ready_Out = accept_en ? grant : '0;

  // Data of the granted requester
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = bus.Req_Data_In[i*DATA_W +: DATA_W];
    end
  end

  // Control FSM: capture on transfer, strobe in LOAD, count down the lockout in HOLD
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
      gid_q    <= '0;
    end else if (Enable_In) begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            data_q <= sel_data;
            gid_q  <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (HOLD_CYCLES == 0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= HOLD_CNT_W'(HOLD_CYCLES);
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt <= HOLD_CNT_W'(1)) begin
            hold_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          hold_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // The strobe is the LOAD state itself, suppressed while frozen so it fires once on resume
  assign bus.Load_Data_Signal_Out = (state == ST_LOAD) && Enable_In;
  assign bus.Busy_Out             = (state != ST_IDLE);
  assign bus.Parallel_Data_Out    = data_q;
  assign bus.Grant_Id_Out         = gid_q;

endmodule

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, data width matching the target PIPO register.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, post-load lockout cycles (0..15).
REQ-004 SHALL have port Clk_In  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_In  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port Enable_In  input  1  global enable; low freezes the block.
REQ-007 SHALL have port Req_Valid_In  input  N_REQ  per-requester load request.
REQ-008 SHALL have port Req_Data_In  input  N_REQ*DATA_W  request data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port Req_Ready_Out  output  N_REQ  per-requester accept, one-hot or zero.
REQ-010 SHALL have port Load_Data_Signal_Out  output  1  load strobe to the PIPO register.
REQ-011 SHALL have port Parallel_Data_Out  output  DATA_W  data to the PIPO register.
REQ-012 SHALL have port Grant_Id_Out  output  clog2(N_REQ)  index of the last accepted requester.
REQ-013 SHALL have port Busy_Out  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, HOLD.
REQ-015 Req_Ready_Out[i] SHALL be combinational: 1 only when state==IDLE, Enable_In==1, and the arbiter grants i.
REQ-016 A transfer SHALL occur on a rising edge where Req_Valid_In[i] and Req_Ready_Out[i] are both 1; Parallel_Data_Out and Grant_Id_Out register the data and i; state goes to LOAD.
REQ-017 In LOAD, Load_Data_Signal_Out SHALL be 1 for exactly one cycle; next state SHALL be HOLD, or IDLE if HOLD_CYCLES==0.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles via a down-counter loaded on LOAD exit, then return to IDLE.
REQ-019 Parallel_Data_Out SHALL stay stable from transfer until the next transfer.
REQ-020 Latency from accepting edge to strobe SHALL be 1 cycle; minimum spacing between transfers SHALL be 2+HOLD_CYCLES cycles.
REQ-021 The default arbiter SHALL be round-robin: search starts at (last grant+1) mod N_REQ; after reset the pointer starts at index 0.
REQ-022 With no valid request in IDLE, the block SHALL remain in IDLE with all Req_Ready_Out at 0.
REQ-023 Enable_In==0 SHALL freeze state, counter, pointer and data; force Load_Data_Signal_Out and Req_Ready_Out to 0; the sequence SHALL resume where it stopped when Enable_In returns to 1.
REQ-024 Requests that drop Req_Valid_In before acceptance SHALL be ignored and SHALL NOT advance the pointer.

Reset
REQ-025 Reset_In high SHALL immediately force state IDLE, counter 0, pointer 0, Parallel_Data_Out 0, Grant_Id_Out 0, Load_Data_Signal_Out 0, Busy_Out 0; an in-flight LOAD or HOLD SHALL be abandoned.

Configuration
REQ-026 Macro PIPO_ARB_FIXED_PRIO_EN defined SHALL select fixed priority, where the lowest index wins and the pointer is unused; undefined SHALL select round-robin per REQ-021.

Structure
REQ-027 Package pipo_ctrl_pkg SHALL hold the state enum and the HOLD counter width constant.
REQ-028 Arbitration SHALL be a sub-module pipo_rr_arbiter with request vector in, and one-hot grant and pointer update out.

Verification
REQ-029 Single request: Req_Valid_In=4'b0100, data 16'hA5A5 -> Req_Ready_Out[2] high; next cycle strobe=1 with Parallel_Data_Out=A5A5 and Grant_Id_Out=2; Busy_Out high for 1+HOLD_CYCLES=3 cycles.
REQ-030 All four requesters held valid -> grants in order 0,1,2,3,0, with transfers exactly 4 cycles apart.
REQ-031 PIPO_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 held valid -> requester 1 is granted on every transfer.
REQ-032 Enable_In low for 3 cycles during HOLD -> no strobe and counter frozen; HOLD completes with its remaining cycles after Enable_In returns high.
REQ-033 Reset_In asserted mid-HOLD -> all outputs 0 in the same cycle; the next request after release is granted starting from index 0.
